pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8, max consecutive data-memory wait cycles before error (legal 1..255).
REQ-002 SHALL have port Clk  input  1  rising-edge clock.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Rs_ID, Rt_ID  input  5 each  source register fields of instruction in ID.
REQ-005 SHALL have port UsesRt_ID  input  1  ID instruction reads Rt as a source.
REQ-006 SHALL have port MemRead_EX, RegWrite_EX  input  1 each  EX-stage control bits.
REQ-007 SHALL have port WriteReg_EX  input  5  EX-stage destination register.
REQ-008 SHALL have port MemRead_MEM, MemWrite_MEM  input  1 each  MEM-stage data-memory access.
REQ-009 SHALL have port MemReady  input  1  data memory completes the current access this cycle.
REQ-010 SHALL have port BranchTaken_EX  input  1  branch resolved taken in EX.
REQ-011 SHALL have port Jump_ID  input  2  jump type decoded in ID (0 = none).
REQ-012 SHALL have ports PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write  output  1 each  stage-register load enables.
REQ-013 SHALL have ports IFID_Flush, IDEX_Flush  output  1 each  insert bubble into that stage register on next edge.
REQ-014 SHALL have port MemReq  output  1  request to data memory.
REQ-015 SHALL have port MemErr  output  1  sticky memory-timeout error.
REQ-016 SHALL have port StallCycles  output  16  saturating count of cycles with PCWrite=0.

Function
REQ-017 SHALL implement registered FSM states RUN, MEM_WAIT, ERROR; all control outputs combinational from state and current inputs.
REQ-018 SHALL define MemAccess = MemRead_MEM | MemWrite_MEM; MemStall = MemAccess & ~MemReady, in RUN and MEM_WAIT only.
REQ-019 SHALL drive MemReq = MemAccess in RUN and MEM_WAIT, 0 in ERROR.
REQ-020 SHALL, on MemStall, drive all five write enables 0 and both flushes 0 (full freeze, same cycle); MemStall has highest priority.
REQ-021 SHALL, without MemStall, treat BranchTaken_EX=1 as redirect: IFID_Flush=1, IDEX_Flush=1, all write enables 1.
REQ-022 SHALL, without MemStall or BranchTaken_EX, treat Jump_ID!=0 as redirect: IFID_Flush=1 only, all write enables 1.
REQ-023 SHALL detect load-use = MemRead_EX & RegWrite_EX & (WriteReg_EX!=0) & ((WriteReg_EX==Rs_ID) | (UsesRt_ID & WriteReg_EX==Rt_ID)).
REQ-024 SHALL, on load-use without MemStall or BranchTaken_EX, drive PCWrite=0, IFID_Write=0, IDEX_Flush=1, other enables 1; load-use beats Jump_ID (IFID_Flush=0).
REQ-025 SHALL otherwise drive all write enables 1 and both flushes 0.
REQ-026 SHALL transition RUN->MEM_WAIT on MemStall; MEM_WAIT->RUN on first cycle MemStall=0; MEM_WAIT stays while MemStall=1.
REQ-027 SHALL keep 8-bit WaitCnt = consecutive stall cycles already elapsed; cleared whenever MemStall=0, incremented on each MemStall cycle.
REQ-028 SHALL transition to ERROR at the edge ending a MemStall cycle with WaitCnt==MEM_TIMEOUT-1 (MEM_TIMEOUT stall cycles total).
REQ-029 SHALL, in ERROR, drive all write enables 0, flushes 0, MemReq 0, MemErr 1; exit only by Reset.
REQ-030 SHALL increment StallCycles on every edge where PCWrite=0 (including ERROR), saturating at 16'hFFFF.
REQ-031 SHALL ignore MemReady when MemAccess=0.

Reset
REQ-032 SHALL on Reset asynchronously enter RUN, WaitCnt=0, StallCycles=0, MemErr=0.
REQ-033 SHALL, during and after Reset with idle inputs, drive all write enables 1, flushes 0, MemReq 0.
REQ-034 SHALL abandon MEM_WAIT or ERROR immediately on Reset assertion mid-operation.

Verification
REQ-035 Load-use: MemRead_EX=1, RegWrite_EX=1, WriteReg_EX=5, Rs_ID=5 -> PCWrite=0, IFID_Write=0, IDEX_Flush=1 one cycle; StallCycles=1; with WriteReg_EX=0 -> no stall.
REQ-036 Mem wait: MemRead_MEM=1, MemReady=0 for 3 cycles then 1 -> 3 frozen cycles, MEM_WAIT entered, RUN on 4th cycle, StallCycles=3, MemErr=0.
REQ-037 Timeout: MEM_TIMEOUT=4, MemWrite_MEM=1, MemReady held 0 -> ERROR after 4th stall edge, MemErr=1, MemReq=0, stays until Reset.
REQ-038 Priority: BranchTaken_EX=1 with load-use and Jump_ID=2 -> IFID_Flush=1, IDEX_Flush=1, PCWrite=1; add MemStall -> full freeze, no flush.
REQ-039 Saturation/reset: force 65540 stall cycles -> StallCycles=16'hFFFF; assert Reset mid-MEM_WAIT -> RUN, counters 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control with load-use detection and data-memory wait/timeout FSM
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UsesRt_ID,
  input  logic        MemRead_EX,
  input  logic        RegWrite_EX,
  input  logic [4:0]  WriteReg_EX,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        MemReady,
  input  logic        BranchTaken_EX,
  input  logic [1:0]  Jump_ID,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        EXMEM_Write,
  output logic        MEMWB_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        MemReq,
  output logic        MemErr,
  output logic [15:0] StallCycles
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t state;
  logic [7:0] wait_cnt;
  logic err, mem_access, mem_stall, load_use, timeout, freeze;
  assign err        = state == ERROR;
  assign mem_access = MemRead_MEM | MemWrite_MEM;
  assign mem_stall  = !err && mem_access && !MemReady;
  assign load_use   = MemRead_EX && RegWrite_EX && WriteReg_EX != 5'd0 &&
                      (WriteReg_EX == Rs_ID || (UsesRt_ID && WriteReg_EX == Rt_ID));
  assign timeout    = wait_cnt == 8'(MEM_TIMEOUT - 1);
  assign freeze     = err || mem_stall;
  // A taken branch squashes the load-use bubble since the dependent instruction is discarded anyway.
  assign PCWrite     = !freeze && (BranchTaken_EX || !load_use);
  assign IFID_Write  = !freeze && (BranchTaken_EX || !load_use);
  assign IDEX_Write  = !freeze;
  assign EXMEM_Write = !freeze;
  assign MEMWB_Write = !freeze;
  assign IFID_Flush  = !freeze && (BranchTaken_EX || (!load_use && Jump_ID != 2'd0));
  assign IDEX_Flush  = !freeze && (BranchTaken_EX || load_use);
  assign MemReq      = !err && mem_access;
  assign MemErr      = err;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      StallCycles <= '0;
    end else begin
      state    <= mem_stall ? (timeout ? ERROR : MEM_WAIT) : (err ? ERROR : RUN);
      wait_cnt <= mem_stall ? wait_cnt + 8'd1 : 8'd0;
      if (!PCWrite && StallCycles != 16'hFFFF) StallCycles <= StallCycles + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks against a behavioural hazard model
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  logic Clk = 0, Reset = 1;
  logic [4:0] Rs_ID, Rt_ID, WriteReg_EX;
  logic UsesRt_ID, MemRead_EX, RegWrite_EX, MemRead_MEM, MemWrite_MEM, MemReady, BranchTaken_EX;
  logic [1:0] Jump_ID;
  logic PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write, IFID_Flush, IDEX_Flush, MemReq, MemErr;
  logic [15:0] StallCycles;
  int n_chk = 0, n_fail = 0;
  bit m_err;
  int m_streak, m_stalls;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .WriteReg_EX(WriteReg_EX),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .MemReady(MemReady),
    .BranchTaken_EX(BranchTaken_EX), .Jump_ID(Jump_ID), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .IDEX_Write(IDEX_Write), .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .MemReq(MemReq), .MemErr(MemErr),
    .StallCycles(StallCycles)
  );

  always #5 Clk = ~Clk;

  function automatic bit m_memstall();
    return !m_err && (MemRead_MEM || MemWrite_MEM) && !MemReady;
  endfunction

  // Expected {PCWrite,IFID_Write,IDEX_Write,EXMEM_Write,MEMWB_Write,IFID_Flush,IDEX_Flush,MemReq,MemErr}
  function automatic logic [8:0] m_out();
    bit acc = MemRead_MEM || MemWrite_MEM;
    bit lu = MemRead_EX && RegWrite_EX && WriteReg_EX != 0 &&
             (WriteReg_EX == Rs_ID || (UsesRt_ID && WriteReg_EX == Rt_ID));
    if (m_err) return 9'b00000_00_0_1;
    if (m_memstall()) return {5'b00000, 2'b00, acc, 1'b0};
    if (BranchTaken_EX) return {5'b11111, 2'b11, acc, 1'b0};
    if (lu) return {5'b00111, 2'b01, acc, 1'b0};
    if (Jump_ID != 0) return {5'b11111, 2'b10, acc, 1'b0};
    return {5'b11111, 2'b00, acc, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag);
    chk({tag, "_ctl"}, 16'({PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
                            IFID_Flush, IDEX_Flush, MemReq, MemErr}), 16'(m_out()));
    chk({tag, "_stall"}, StallCycles, 16'(m_stalls));
  endtask

  function automatic void m_edge();
    if (!m_out()[8]) m_stalls = m_stalls == 65535 ? 65535 : m_stalls + 1;
    if (m_memstall()) begin
      m_streak++;
      if (m_streak == TO) m_err = 1;
    end else m_streak = 0;
  endfunction

  task automatic step(input string tag);
    #4;
    check_now(tag);
    @(posedge Clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    {Rs_ID, Rt_ID, WriteReg_EX} = '0;
    {UsesRt_ID, MemRead_EX, RegWrite_EX, MemRead_MEM, MemWrite_MEM, BranchTaken_EX} = '0;
    MemReady = 1;
    Jump_ID = 0;
  endtask

  task automatic do_reset(input string tag);
    Reset = 1;
    idle();
    #1;
    m_err = 0; m_streak = 0; m_stalls = 0;
    check_now(tag);
    chk({tag, "_ctl_const"}, 16'({PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush, MemReq, MemErr}),
        16'b1110000);
    #2;
    Reset = 0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    idle();
    m_err = 0; m_streak = 0; m_stalls = 0;
    #12;
    do_reset("reset");
    step("idle");
    // load-use on Rs, then same pattern with r0 destination
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 5; Rs_ID = 5;
    step("loaduse");
    idle();
    step("after_lu");
    chk("lu_count", StallCycles, 16'd1);
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 0; Rs_ID = 0;
    step("lu_r0");
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 7; Rt_ID = 7; UsesRt_ID = 0;
    step("rt_unused");
    UsesRt_ID = 1;
    step("rt_used");
    idle();
    // memory wait: three frozen cycles then ready
    do_reset("reset2");
    MemRead_MEM = 1; MemReady = 0;
    repeat (3) step("memwait");
    MemReady = 1;
    step("memdone");
    idle();
    step("memidle");
    chk("memwait_count", StallCycles, 16'd3);
    chk("memwait_err", 16'(MemErr), 16'd0);
    // timeout into ERROR
    MemWrite_MEM = 1; MemReady = 0;
    repeat (TO) step("timeout");
    chk("err_set", 16'(MemErr), 16'd1);
    chk("err_req", 16'(MemReq), 16'd0);
    MemReady = 1;
    repeat (3) step("err_hold");
    idle();
    step("err_idle");
    // priority: branch over load-use and jump, memstall over all
    do_reset("reset3");
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 9; Rs_ID = 9; Jump_ID = 2; BranchTaken_EX = 1;
    step("prio_br");
    BranchTaken_EX = 0;
    step("prio_lu");
    MemRead_EX = 0;
    step("prio_jmp");
    BranchTaken_EX = 1; MemRead_MEM = 1; MemReady = 0;
    step("prio_ms");
    idle();
    // reset in the middle of MEM_WAIT
    MemRead_MEM = 1; MemReady = 0;
    repeat (2) step("pre_rst");
    do_reset("rst_memwait");
    chk("rst_count", StallCycles, 16'd0);
    // saturation via ERROR state
    MemWrite_MEM = 1; MemReady = 0;
    repeat (TO) step("sat_enter");
    idle();
    for (int i = 0; i < 65540; i++) begin
      @(posedge Clk);
      m_edge();
    end
    #1;
    check_now("sat");
    chk("sat_const", StallCycles, 16'hFFFF);
    step("sat_hold");
    do_reset("reset4");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (m_err && $urandom_range(3) == 0) do_reset("rnd_rst");
      Rs_ID = 5'($urandom_range(3)); Rt_ID = 5'($urandom_range(3)); WriteReg_EX = 5'($urandom_range(3));
      UsesRt_ID = 1'($urandom); MemRead_EX = 1'($urandom); RegWrite_EX = 1'($urandom);
      MemRead_MEM = $urandom_range(3) == 0; MemWrite_MEM = $urandom_range(4) == 0;
      MemReady = $urandom_range(3) != 0; BranchTaken_EX = $urandom_range(5) == 0;
      Jump_ID = 2'($urandom);
      step("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
